// File: rtl/player_motion.sv
// player_motion: per-frame player sprite anchor generator.
// Moves the sprite horizontally with screen-edge clamping and runs a
// grounded/rising/falling jump machine. Every state change is gated by
// frame_tick, so the anchors stay stable between frames.
module player_motion #(
  parameter int SCREEN_W = 320,
  parameter int SPR_W    = 20,
  parameter int GROUND_Y = 184,
  parameter int X_STEP   = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  output logic [8:0] x_anchor,
  output logic [8:0] y_anchor,
  output logic       airborne,
  output logic       facing_left,
  output logic       landed,
  output logic       update_done
);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam logic [9:0] X_MAX_W    = 10'(SCREEN_W - SPR_W);
  localparam logic [9:0] X_STEP_W   = 10'(X_STEP);
  localparam logic [9:0] GROUND_W   = 10'(GROUND_Y);
  localparam logic [9:0] GRAVITY_W  = 10'(GRAVITY);
  localparam logic [9:0] MAX_FALL_W = 10'(MAX_FALL);
  localparam logic [8:0] GROUND_9   = 9'(GROUND_Y);
  localparam logic [4:0] JUMP_V_5   = 5'(JUMP_V);
  localparam logic [4:0] GRAVITY_5  = 5'(GRAVITY);
  localparam logic [4:0] MAX_FALL_5 = 5'(MAX_FALL);

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [4:0] spd_q, spd_d;
  logic       facing_q, facing_d;
  logic       landed_q, landed_d;
  logic       done_q, done_d;

  logic [9:0] x_wide;
  logic [9:0] x_sum;
  logic [9:0] y_wide;
  logic [9:0] spd_wide;
  logic [9:0] fall_sum;
  logic [9:0] spd_next;

  // State register: every flop of the block, cleared immediately on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= GROUNDED;
      x_q      <= '0;
      y_q      <= GROUND_9;
      spd_q    <= '0;
      facing_q <= 1'b0;
      landed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      spd_q    <= spd_d;
      facing_q <= facing_d;
      landed_q <= landed_d;
      done_q   <= done_d;
    end
  end

  // Horizontal stepping: one step per tick, clamped at both screen edges.
  always_comb begin
    x_d      = x_q;
    facing_d = facing_q;
    x_wide   = {1'b0, x_q};
    x_sum    = x_wide + X_STEP_W;
    if (frame_tick) begin
      if (move_right && !move_left) begin
        x_d      = (x_sum > X_MAX_W) ? X_MAX_W[8:0] : x_sum[8:0];
        facing_d = 1'b0;
      end else if (move_left && !move_right) begin
        x_d      = (x_wide < X_STEP_W) ? 9'd0 : (x_q - X_STEP_W[8:0]);
        facing_d = 1'b1;
      end
    end
  end

  // Vertical next-state: jump launch, decelerating rise, accelerating fall.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    spd_d    = spd_q;
    landed_d = 1'b0;
    done_d   = frame_tick;
    y_wide   = {1'b0, y_q};
    spd_wide = {5'b0, spd_q};
    fall_sum = y_wide + spd_wide;
    spd_next = spd_wide + GRAVITY_W;
    if (frame_tick) begin
      case (state_q)
        GROUNDED: begin
          y_d = GROUND_9;
          if (jump) begin
            spd_d   = JUMP_V_5;
            state_d = RISING;
          end
        end
        RISING: begin
          if (y_wide < spd_wide) begin
            y_d     = '0;
            spd_d   = '0;
            state_d = FALLING;
          end else begin
            y_d = y_q - {4'b0, spd_q};
            if (spd_q <= GRAVITY_5) begin
              spd_d   = '0;
              state_d = FALLING;
            end else begin
              spd_d = spd_q - GRAVITY_5;
            end
          end
        end
        FALLING: begin
          if (fall_sum >= GROUND_W) begin
            y_d      = GROUND_9;
            spd_d    = '0;
            state_d  = GROUNDED;
            landed_d = 1'b1;
          end else begin
            y_d   = fall_sum[8:0];
            spd_d = (spd_next > MAX_FALL_W) ? MAX_FALL_5 : spd_next[4:0];
          end
        end
        default: begin
          y_d     = GROUND_9;
          spd_d   = '0;
          state_d = GROUNDED;
        end
      endcase
    end
  end

  // Outputs come straight from registers so they only move after a tick.
  always_comb begin
    x_anchor    = x_q;
    y_anchor    = y_q;
    airborne    = (state_q != GROUNDED);
    facing_left = facing_q;
    landed      = landed_q;
    update_done = done_q;
  end

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: randomized and directed stimulus for player_motion with a
// queue-based scoreboard fed by a simple arithmetic motion model.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       jump = 1'b0;
  logic [8:0] x_anchor;
  logic [8:0] y_anchor;
  logic       airborne;
  logic       facing_left;
  logic       landed;
  logic       update_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int x;
    int y;
    bit air;
    bit face;
    bit land;
    int issued;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  // Reference model state: phase 0 on ground, 1 going up, 2 coming down.
  int m_x, m_y, m_spd, m_phase;
  bit m_face;

  player_motion dut (
    .clk(clk),
    .resetn(resetn),
    .frame_tick(frame_tick),
    .move_left(move_left),
    .move_right(move_right),
    .jump(jump),
    .x_anchor(x_anchor),
    .y_anchor(y_anchor),
    .airborne(airborne),
    .facing_left(facing_left),
    .landed(landed),
    .update_done(update_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic void modelReset();
    m_x = 0; m_y = 184; m_spd = 0; m_phase = 0; m_face = 1'b0;
  endfunction

  // One frame of motion computed directly from the movement rules.
  function automatic exp_t modelTick(input bit l, input bit r, input bit j);
    exp_t e;
    bit lnd = 1'b0;
    if (r && !l) begin
      m_x = (m_x + 4 > 300) ? 300 : m_x + 4;
      m_face = 1'b0;
    end else if (l && !r) begin
      m_x = (m_x < 4) ? 0 : m_x - 4;
      m_face = 1'b1;
    end
    if (m_phase == 0) begin
      m_y = 184;
      if (j) begin m_spd = 12; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (m_y < m_spd) begin
        m_y = 0; m_spd = 0; m_phase = 2;
      end else begin
        m_y -= m_spd;
        if (m_spd <= 1) begin m_spd = 0; m_phase = 2; end
        else m_spd -= 1;
      end
    end else begin
      if (m_y + m_spd >= 184) begin
        m_y = 184; m_spd = 0; m_phase = 0; lnd = 1'b1;
      end else begin
        m_y += m_spd;
        m_spd = (m_spd + 1 > 12) ? 12 : m_spd + 1;
      end
    end
    e.x = m_x; e.y = m_y; e.air = (m_phase != 0); e.face = m_face;
    e.land = lnd; e.issued = cyc;
    return e;
  endfunction

  // Issue one tick at a negedge; returns at the next negedge with results visible.
  task automatic applyStimulus(input bit l, input bit r, input bit j);
    move_left  = l;
    move_right = r;
    jump       = j;
    frame_tick = 1'b1;
    sb.push_back(modelTick(l, r, j));
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idleCycles(input int n, input bit scramble);
    repeat (n) begin
      if (scramble) begin
        move_left  = 1'($urandom);
        move_right = 1'($urandom);
        jump       = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor: pops one expectation per update_done pulse and
  // checks that outputs hold still on every other cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      sb.delete();
      last.x = 0; last.y = 184; last.air = 1'b0; last.face = 1'b0; last.land = 1'b0;
    end else if (update_done) begin
      checkOutput("done_has_tick", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("x_anchor", int'(x_anchor), e.x);
        checkOutput("y_anchor", int'(y_anchor), e.y);
        checkOutput("airborne", int'(airborne), int'(e.air));
        checkOutput("facing_left", int'(facing_left), int'(e.face));
        checkOutput("landed", int'(landed), int'(e.land));
        last = e;
        last.land = 1'b0;
      end
    end else begin
      if (sb.size() > 0 && sb[0].issued + 1 < cyc) begin
        checkOutput("done_pulse", int'(update_done), 1);
        last = sb.pop_front();
        last.land = 1'b0;
      end
      checkOutput("hold", int'({x_anchor, y_anchor, airborne, facing_left, landed}),
                  int'({9'(last.x), 9'(last.y), last.air, last.face, 1'b0}));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_x", int'(x_anchor), 0);
    checkOutput("reset_y", int'(y_anchor), 184);
    checkOutput("reset_air", int'(airborne), 0);
    checkOutput("reset_done", int'(update_done), 0);
    resetn = 1'b1;
    idleCycles(2, 1'b0);

    // Walk right to the clamp.
    for (int k = 1; k <= 80; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 1)  checkOutput("walk_r_t1", int'(x_anchor), 4);
      if (k == 75) checkOutput("walk_r_t75", int'(x_anchor), 300);
    end
    checkOutput("walk_r_clamp", int'(x_anchor), 300);

    // Both directions pressed together: no motion.
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_hold", int'(x_anchor), 300);

    // Walk left to zero and verify no wrap.
    for (int k = 1; k <= 80; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("walk_l_clamp", int'(x_anchor), 0);
    checkOutput("walk_l_face", int'(facing_left), 1);

    // Single jump pulse.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jump_t1_y", int'(y_anchor), 184);
    checkOutput("jump_t1_air", int'(airborne), 1);
    for (int k = 2; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (k == 13) checkOutput("jump_apex", int'(y_anchor), 106);
      if (k == 25) checkOutput("jump_t25_air", int'(airborne), 1);
      if (k == 26) begin
        checkOutput("jump_land_y", int'(y_anchor), 184);
        checkOutput("jump_land_pulse", int'(landed), 1);
        checkOutput("jump_land_air", int'(airborne), 0);
      end
    end

    // Held jump relaunches the tick after landing.
    for (int k = 1; k <= 28; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k == 26) checkOutput("held_land", int'(landed), 1);
      if (k == 27) begin
        checkOutput("held_relaunch_y", int'(y_anchor), 184);
        checkOutput("held_relaunch_air", int'(airborne), 1);
      end
      if (k == 28) checkOutput("held_t28_y", int'(y_anchor), 172);
    end

    // Input activity with no ticks must not move anything.
    idleCycles(1000, 1'b1);

    // Randomized play with random gaps, including back-to-back ticks.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3), 1'b1);
    end

    // Asynchronous reset mid-jump.
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("areset_x", int'(x_anchor), 0);
    checkOutput("areset_y", int'(y_anchor), 184);
    checkOutput("areset_air", int'(airborne), 0);
    checkOutput("areset_face", int'(facing_left), 0);
    @(negedge clk);
    repeat (4) begin
      frame_tick = 1'b1;
      move_right = 1'b1;
      jump = 1'b1;
      @(negedge clk);
    end
    frame_tick = 1'b0;
    checkOutput("in_reset_x", int'(x_anchor), 0);
    checkOutput("in_reset_done", int'(update_done), 0);
    resetn = 1'b1;
    idleCycles(2, 1'b0);
    for (int k = 0; k < 40; k++)
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));

    // Let any outstanding expectation drain, bounded.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
